race_sequencer: RTL and testbench

//   Top-level game controller for the two-car race. Generates the shared game tick.

---
 rtl/race_pkg.sv | 22 ++
 rtl/race_sequencer_tick_gen.sv | 34 +++
 rtl/race_sequencer.sv | 150 +++++++++++++++
 tb/tb_race_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// Shared game-state and winner codes for the race sequencer and both physics engines.
package race_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ARM    = 3'd1,
      ST_COUNT  = 3'd2,
      ST_PAUSE  = 3'd3,
      ST_RACE   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;
   localparam logic [1:0] WIN_TIE  = 2'd3;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/race_sequencer_tick_gen.sv
// Free-running divider producing a registered one-clock game_tick every CLK_FREQ/TICK_HZ clocks.
module tick_gen #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 120
) (
   input  logic clk,
   input  logic rst,
   output logic game_tick
);

   localparam int TICK_LIMIT = CLK_FREQ / TICK_HZ;
   localparam int DIV_W      = (TICK_LIMIT > 1) ? $clog2(TICK_LIMIT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_LIMIT - 1);

   logic [DIV_W-1:0] r_div;
   logic             r_tick;
   logic             w_wrap;

   assign w_wrap = (r_div == DIV_LAST);

   // Registering the pulse places the first tick exactly TICK_LIMIT clocks after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap;
         r_div  <= w_wrap ? '0 : r_div + 1'b1;
      end
   end

   assign game_tick = r_tick;

endmodule

// File: rtl/race_sequencer.sv
// Two-car race controller: game tick, countdown, race timer and finish arbitration.
// Optional race time limit is enabled by defining RACE_TIMEOUT_EN.
module race_sequencer
   import race_pkg::*;
#(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int TICK_HZ         = 120,
   parameter int COUNT_SEC       = 3,
   parameter int FINISH_HOLD_SEC = 5,
   parameter int TIMEOUT_SEC     = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_btn,
   input  logic        pause_btn,
   input  logic        p1_finish,
   input  logic        p2_finish,
   output logic [2:0]  state,
   output logic        engine_rst,
   output logic        game_tick,
   output logic [1:0]  countdown,
   output logic [15:0] race_ticks,
   output logic [1:0]  winner
);

`ifdef RACE_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   localparam logic [15:0] SEC_LAST      = 16'(TICK_HZ - 1);
   localparam logic [15:0] HOLD_LAST     = 16'(FINISH_HOLD_SEC * TICK_HZ - 1);
   localparam logic [15:0] TIMEOUT_TICKS = 16'(TIMEOUT_SEC * TICK_HZ);

   state_t      r_state;
   state_t      w_next;
   logic        r_start_d, r_pause_d;
   logic        r_start_edge, r_pause_edge;
   logic [1:0]  r_countdown;
   logic [15:0] r_race_ticks;
   logic [1:0]  r_winner;
   logic [15:0] r_sec_cnt;
   logic [15:0] r_hold_cnt;
   logic        w_tick;
   logic        w_any_finish;
   logic        w_sec_done;
   logic        w_timeout;

   tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_HZ  (TICK_HZ)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .game_tick (w_tick)
   );

   assign w_any_finish = p1_finish | p2_finish;
   assign w_sec_done   = w_tick && (r_sec_cnt == SEC_LAST);
   assign w_timeout    = TIMEOUT_EN && (r_race_ticks >= TIMEOUT_TICKS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_d    <= 1'b0;
         r_pause_d    <= 1'b0;
         r_start_edge <= 1'b0;
         r_pause_edge <= 1'b0;
      end else begin
         r_start_d    <= start_btn;
         r_pause_d    <= pause_btn;
         r_start_edge <= start_btn & ~r_start_d;
         r_pause_edge <= pause_btn & ~r_pause_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (r_start_edge) w_next = ST_ARM;
         ST_ARM:    w_next = ST_COUNT;
         ST_COUNT:  if (w_sec_done && r_countdown == 2'd1) w_next = ST_RACE;
         // A real finish outranks both a pause edge and the time limit
         ST_RACE: begin
            if (w_any_finish)      w_next = ST_FINISH;
            else if (r_pause_edge) w_next = ST_PAUSE;
            else if (w_timeout)    w_next = ST_FINISH;
         end
         ST_PAUSE:  if (r_pause_edge) w_next = ST_RACE;
         ST_FINISH: begin
            if (r_start_edge)                           w_next = ST_ARM;
            else if (w_tick && r_hold_cnt == HOLD_LAST) w_next = ST_IDLE;
         end
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_countdown  <= 2'd0;
         r_race_ticks <= 16'd0;
         r_winner     <= WIN_NONE;
         r_sec_cnt    <= 16'd0;
      end else begin
         case (r_state)
            ST_ARM: begin
               r_winner     <= WIN_NONE;
               r_race_ticks <= 16'd0;
               r_countdown  <= 2'(COUNT_SEC);
               r_sec_cnt    <= 16'd0;
            end
            ST_COUNT: begin
               if (w_sec_done) begin
                  r_sec_cnt   <= 16'd0;
                  r_countdown <= r_countdown - 2'd1;
               end else if (w_tick) begin
                  r_sec_cnt <= r_sec_cnt + 16'd1;
               end
            end
            ST_RACE: begin
               if (w_tick) r_race_ticks <= sat_inc16(r_race_ticks);
               if (p1_finish && p2_finish) r_winner <= WIN_TIE;
               else if (p1_finish)         r_winner <= WIN_P1;
               else if (p2_finish)         r_winner <= WIN_P2;
               else if (!r_pause_edge && w_timeout) r_winner <= WIN_NONE;
            end
            default: ;
         endcase
      end
   end

   // Hold timer only runs while FINISH is displayed; any other state rearms it
   always_ff @(posedge clk) begin
      if (rst || r_state != ST_FINISH) r_hold_cnt <= 16'd0;
      else if (w_tick)                 r_hold_cnt <= r_hold_cnt + 16'd1;
   end

   assign state      = r_state;
   assign engine_rst = (r_state == ST_ARM);
   assign game_tick  = w_tick;
   assign countdown  = r_countdown;
   assign race_ticks = r_race_ticks;
   assign winner     = r_winner;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer at a 10-clock tick period.
module tb_race_sequencer;
   import race_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start_btn, pause_btn, p1_finish, p2_finish;
   logic [2:0]  state;
   logic        engine_rst, game_tick;
   logic [1:0]  countdown;
   logic [15:0] race_ticks;
   logic [1:0]  winner;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] rt_saved;

   always #5 clk = ~clk;

   race_sequencer #(
      .CLK_FREQ        (1200),
      .TICK_HZ         (120),
      .COUNT_SEC       (3),
      .FINISH_HOLD_SEC (5),
      .TIMEOUT_SEC     (1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_btn  (start_btn),
      .pause_btn  (pause_btn),
      .p1_finish  (p1_finish),
      .p2_finish  (p2_finish),
      .state      (state),
      .engine_rst (engine_rst),
      .game_tick  (game_tick),
      .countdown  (countdown),
      .race_ticks (race_ticks),
      .winner     (winner)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_start();
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      step();
   endtask

   task automatic press_pause();
      pause_btn = 1'b1;
      step();
      pause_btn = 1'b0;
      step();
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
      int i = 0;
      while (state !== s && i < budget) begin
         step();
         i++;
      end
      chk(tag, state, s);
   endtask

   task automatic wait_tick(input string tag);
      int i = 0;
      do begin
         step();
         i++;
      end while (game_tick !== 1'b1 && i < 20);
      chk(tag, game_tick, 1);
   endtask

   // Returns once n ticks have been seen while in state s
   task automatic count_ticks(input logic [2:0] s, input int n, input string tag);
      int c = 0;
      int i = 0;
      while (c < n && i < n * 10 + 20) begin
         step();
         i++;
         if (state === s && game_tick === 1'b1) c++;
      end
      chk(tag, c, n);
   endtask

   // From entry into COUNT to arrival in RACE, optionally poking start mid-countdown
   task automatic run_count(input bit poke, input string tag);
      int c = 0;
      int i = 0;
      chk({tag, "_entry_state"}, state, ST_COUNT);
      chk({tag, "_entry_cd"}, countdown, 3);
      while (state === ST_COUNT && i < 5000) begin
         if (poke) start_btn = (c >= 50 && c < 52);
         step();
         i++;
         if (state === ST_COUNT && game_tick === 1'b1) begin
            c++;
            if (c == 121) chk({tag, "_cd2"}, countdown, 2);
            if (c == 241) chk({tag, "_cd1"}, countdown, 1);
         end
      end
      start_btn = 1'b0;
      chk({tag, "_ticks"}, c, 360);
      chk({tag, "_race"}, state, ST_RACE);
      chk({tag, "_cd0"}, countdown, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; p1_finish = 1'b0; p2_finish = 1'b0;
      step();
      step();
      chk("rst_state", state, ST_IDLE);
      chk("rst_engine_rst", engine_rst, 0);
      chk("rst_tick", game_tick, 0);
      chk("rst_cd", countdown, 0);
      chk("rst_rt", race_ticks, 0);
      chk("rst_winner", winner, 0);
      rst = 1'b0;

      // 1: idle tick cadence
      for (int n = 1; n <= 35; n++) begin
         step();
         chk($sformatf("idle_tick_%0d", n), game_tick, (n % 10 == 0));
      end
      chk("idle_state", state, ST_IDLE);
      chk("idle_engine_rst", engine_rst, 0);
      chk("idle_rt", race_ticks, 0);

      // 2: start, ARM pulse, countdown
      start_btn = 1'b1;
      step();
      chk("start_registered", state, ST_IDLE);
      start_btn = 1'b0;
      step();
      chk("arm_state", state, ST_ARM);
      chk("arm_engine_rst", engine_rst, 1);
      step();
      chk("count_engine_rst", engine_rst, 0);
      run_count(1'b0, "cnt1");

      // 3: simultaneous finish gives a tie
      wait_tick("t3_sync");
      step(); step(); step();
      chk("t3_rt", race_ticks, 1);
      p1_finish = 1'b1; p2_finish = 1'b1;
      step();
      p1_finish = 1'b0; p2_finish = 1'b0;
      chk("tie_state", state, ST_FINISH);
      chk("tie_winner", winner, WIN_TIE);
      rt_saved = race_ticks;
      count_ticks(ST_FINISH, 599, "hold_599");
      chk("hold_not_yet", state, ST_FINISH);
      count_ticks(ST_FINISH, 1, "hold_600");
      step();
      chk("hold_idle", state, ST_IDLE);
      chk("hold_winner", winner, WIN_TIE);
      chk("hold_rt_frozen", race_ticks, rt_saved);

      // 4: pause freezes race time and ignores finish
      press_start();
      chk("t4_arm", state, ST_ARM);
      chk("t4_arm_winner_old", winner, WIN_TIE);
      wait_state(ST_RACE, 4000, "t4_race");
      chk("t4_winner_cleared", winner, WIN_NONE);
      count_ticks(ST_RACE, 50, "t4_50");
      step();
      chk("t4_rt50", race_ticks, 50);
      press_pause();
      chk("t4_paused", state, ST_PAUSE);
      p2_finish = 1'b1;
      count_ticks(ST_PAUSE, 100, "t4_pause100");
      chk("t4_pause_state", state, ST_PAUSE);
      chk("t4_pause_rt", race_ticks, 50);
      chk("t4_pause_winner", winner, WIN_NONE);
      p2_finish = 1'b0;
      press_pause();
      chk("t4_resumed", state, ST_RACE);
      count_ticks(ST_RACE, 20, "t4_20");
      step();
      chk("t4_rt70", race_ticks, 70);

      // 5: finish beats a pause edge on the same clock
      pause_btn = 1'b1;
      step();
      p1_finish = 1'b1;
      step();
      pause_btn = 1'b0; p1_finish = 1'b0;
      chk("t5_state", state, ST_FINISH);
      chk("t5_winner", winner, WIN_P1);
      step(); step();
      chk("t5_still_finish", state, ST_FINISH);
      chk("t5_rt", race_ticks, 70);
      press_start();
      chk("t5_restart_arm", state, ST_ARM);
      step();
      run_count(1'b1, "cnt2");

      // 6: timeout (optional) and synchronous reset mid-game
`ifdef RACE_TIMEOUT_EN
      wait_state(ST_FINISH, 1500, "t6_timeout");
      chk("t6_to_winner", winner, WIN_NONE);
      chk("t6_to_rt", race_ticks, 120);
`else
      begin
         int i = 0;
         while (race_ticks !== 16'd200 && i < 2500) begin
            step();
            i++;
         end
      end
      chk("t6_rt200", race_ticks, 200);
      chk("t6_racing", state, ST_RACE);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_rst_state", state, ST_IDLE);
      chk("t6_rst_rt", race_ticks, 0);
      chk("t6_rst_winner", winner, 0);
      chk("t6_rst_cd", countdown, 0);
      chk("t6_rst_tick", game_tick, 0);
      for (int n = 1; n <= 10; n++) begin
         step();
         chk($sformatf("t6_tick_%0d", n), game_tick, (n == 10));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
